// File: rtl/manchester_stream_serializer.sv
// Manchester line coder fed by an AXI-Stream sink, with a one-entry holding register for gap-free streaming.
// Optional MANCHESTER_SYNC_EN: each burst begins with a 6-half-bit code-violation sync symbol.
module manchester_stream_serializer #(
  parameter int   DATA_W    = 8,
  parameter int   HALF_CYC  = 1,
  parameter int   MSB_FIRST = 1,
  parameter int   POLARITY  = 0,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              serial_out,
  output logic              busy
);

  localparam int VEC_W = 2 * DATA_W;
  localparam int CYC_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
`ifdef MANCHESTER_SYNC_EN
  // The index also counts the six sync half-bits, so it needs at least 3 bits.
  localparam int HB_W  = ($clog2(VEC_W) > 3) ? $clog2(VEC_W) : 3;
`else
  localparam int HB_W  = $clog2(VEC_W);
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef MANCHESTER_SYNC_EN
  localparam logic [1:0] ST_SYNC  = 2'd2;
  localparam logic [HB_W-1:0] SYNC_LAST = HB_W'(5);
`endif

  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(VEC_W - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(HALF_CYC - 1);

  // First half-bit to transmit ends up in the MSB of the returned vector.
  function automatic logic [VEC_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [VEC_W-1:0] enc;
    logic             b;
    enc = '0;
    for (int k = 0; k < DATA_W; k++) begin
      b = (MSB_FIRST != 0) ? d[DATA_W-1-k] : d[k];
      enc[VEC_W-1-2*k] = (POLARITY == 0) ? b : ~b;
      enc[VEC_W-2-2*k] = (POLARITY == 0) ? ~b : b;
    end
    return enc;
  endfunction

  logic              holding_q, holding_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [1:0]        state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [HB_W-1:0]   hb_q, hb_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              ser_q, ser_d;
  logic [VEC_W-1:0]  enc_s;

  assign enc_s = encode(hold_data_q);

  always_comb begin
    holding_d   = holding_q;
    hold_data_d = hold_data_q;
    state_d     = state_q;
    vec_d       = vec_q;
    hb_d        = hb_q;
    cyc_d       = cyc_q;
    ser_d       = ser_q;

    if (s_axis_tvalid && !holding_q) begin
      holding_d   = 1'b1;
      hold_data_d = s_axis_tdata;
    end else begin
      hold_data_d = hold_data_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (holding_q) begin
          holding_d = 1'b0;
          hb_d      = '0;
          cyc_d     = '0;
`ifdef MANCHESTER_SYNC_EN
          state_d   = ST_SYNC;
          ser_d     = ~IDLE_LVL;
          vec_d     = enc_s;
`else
          state_d   = ST_SHIFT;
          ser_d     = enc_s[VEC_W-1];
          vec_d     = {enc_s[VEC_W-2:0], 1'b0};
`endif
        end else begin
          ser_d = IDLE_LVL;
        end
      end
      ST_SHIFT: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (hb_q == HB_LAST) begin
            // Last half-bit done: reload seamlessly or fall back to idle level.
            if (holding_q) begin
              holding_d = 1'b0;
              hb_d      = '0;
              ser_d     = enc_s[VEC_W-1];
              vec_d     = {enc_s[VEC_W-2:0], 1'b0};
            end else begin
              state_d = ST_IDLE;
              ser_d   = IDLE_LVL;
            end
          end else begin
            hb_d  = hb_q + HB_W'(1);
            ser_d = vec_q[VEC_W-1];
            vec_d = {vec_q[VEC_W-2:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
`ifdef MANCHESTER_SYNC_EN
      ST_SYNC: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (hb_q == SYNC_LAST) begin
            state_d = ST_SHIFT;
            hb_d    = '0;
            ser_d   = vec_q[VEC_W-1];
            vec_d   = {vec_q[VEC_W-2:0], 1'b0};
          end else begin
            hb_d  = hb_q + HB_W'(1);
            ser_d = (hb_q < HB_W'(2)) ? ~IDLE_LVL : IDLE_LVL;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        ser_d   = IDLE_LVL;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      holding_q   <= 1'b0;
      hold_data_q <= '0;
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      hb_q        <= '0;
      cyc_q       <= '0;
      ser_q       <= IDLE_LVL;
    end else begin
      holding_q   <= holding_d;
      hold_data_q <= hold_data_d;
      state_q     <= state_d;
      vec_q       <= vec_d;
      hb_q        <= hb_d;
      cyc_q       <= cyc_d;
      ser_q       <= ser_d;
    end
  end

  assign s_axis_tready = ~holding_q;
  assign serial_out    = ser_q;
  assign busy          = holding_q | (state_q != ST_IDLE);

endmodule
